// File: rtl/r_cpu_seq_ctrl.sv
// Multi-cycle sequencer for the R-type CPU datapath.
// Splits each instruction into FETCH/DECODE/EXEC/WB, drives the datapath
// write strobes and ALU opcode, traps illegal instructions and (optionally)
// ADD/SUB overflow, and counts retired instructions.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | parked, waiting for runa
//   FETCH  | PC += 4, instruction register loads
//   DECODE | operand latches load, {opa,funca} classified, ALU op latched
//   EXEC   | ALU settles, overflow sampled into the trap bit
//   WB     | register write (unless NOP/trap), instruction retires
//   HALT   | illegal instruction or overflow trap; only reset leaves
module r_cpu_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter bit OF_TRAP = 1'b1
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             runa,
    input  logic [5:0]       opa,
    input  logic [5:0]       funca,
    input  logic             ofa,
    output logic             pc_wea,
    output logic             ir_wea,
    output logic             ab_wea,
    output logic             reg_wea,
    output logic [2:0]       aopa,
    output logic [2:0]       statea,
    output logic             illa,
    output logic             ofta,
    output logic [CNT_W-1:0] retcnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] AOP_ADD = 3'b010;
    localparam logic [2:0] AOP_SUB = 3'b110;

    state_t           state_q, state_d;
    logic [2:0]       aop_q;
    logic             nop_q;
    logic             trap_q;
    logic             ill_q;
    logic             oft_q;
    logic [CNT_W-1:0] retcnt_q;

    logic             dec_legal;
    logic             dec_nop;
    logic [2:0]       dec_aop;

    // Classify the instruction word; only opa=0 R-type functions are legal.
    always_comb begin
        dec_legal = 1'b0;
        dec_nop   = 1'b0;
        dec_aop   = 3'b000;
        if (opa == 6'b000000) begin
            dec_legal = 1'b1;
            unique case (funca)
                6'b100100: dec_aop = 3'b000;
                6'b100101: dec_aop = 3'b001;
                6'b100000: dec_aop = 3'b010;
                6'b100110: dec_aop = 3'b011;
                6'b100111: dec_aop = 3'b100;
                6'b100010: dec_aop = 3'b110;
                6'b101010: dec_aop = 3'b111;
                6'b000000: dec_nop = 1'b1;
                default:   dec_legal = 1'b0;
            endcase
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; unused encodings recover to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (runa) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_d = ST_WB;
            ST_WB: begin
                if (trap_q)    state_d = ST_HALT;
                else if (runa) state_d = ST_FETCH;
                else           state_d = ST_IDLE;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Instruction context, sticky trap flags and the retired counter.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            aop_q    <= 3'b000;
            nop_q    <= 1'b0;
            trap_q   <= 1'b0;
            ill_q    <= 1'b0;
            oft_q    <= 1'b0;
            retcnt_q <= '0;
        end else begin
            case (state_q)
                ST_DECODE: begin
                    if (dec_legal) begin
                        aop_q <= dec_aop;
                        nop_q <= dec_nop;
                    end else begin
                        ill_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // ADD and SUB have unique ALU codes, so aop_q identifies them.
                    trap_q <= OF_TRAP && ofa && ((aop_q == AOP_ADD) || (aop_q == AOP_SUB));
                end
                ST_WB: begin
                    if (trap_q) begin
                        oft_q <= 1'b1;
                    end else if (retcnt_q != {CNT_W{1'b1}}) begin
                        retcnt_q <= retcnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore strobes decoded straight from the state register.
    always_comb begin
        pc_wea  = (state_q == ST_FETCH);
        ir_wea  = (state_q == ST_FETCH);
        ab_wea  = (state_q == ST_DECODE);
        reg_wea = (state_q == ST_WB) && !nop_q && !trap_q;
    end

    assign aopa   = aop_q;
    assign statea = state_q;
    assign illa   = ill_q;
    assign ofta   = oft_q;
    assign retcnt = retcnt_q;

endmodule

// File: tb/tb_r_cpu_seq_ctrl.sv
// Bench for r_cpu_seq_ctrl: two instances (OF_TRAP=1/CNT_W=16 and
// OF_TRAP=0/CNT_W=2) share one stimulus stream and are compared every cycle
// against an instruction-phase reference model, plus directed scenarios.
module tb_r_cpu_seq_ctrl;

    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOP = 6'b000000;

    logic       clka = 1'b0;
    logic       rsta;
    logic       runa;
    logic [5:0] opa;
    logic [5:0] funca;
    logic       ofa;

    logic        pcw [2];
    logic        irw [2];
    logic        abw [2];
    logic        rgw [2];
    logic [2:0]  aop [2];
    logic [2:0]  st  [2];
    logic        ill [2];
    logic        oft [2];
    logic [15:0] ret0;
    logic [1:0]  ret1;

    int checks   = 0;
    int failures = 0;
    int pc_pulses = 0;

    // Reference model state, one slot per instance.
    int m_st   [2];
    int m_aop  [2];
    int m_func [2];
    int m_trap [2];
    int m_ill  [2];
    int m_oft  [2];
    int m_cnt  [2];
    int p_oftrap [2] = '{1, 0};
    int p_cntmax [2] = '{65535, 3};

    logic [5:0] legal_f [8] = '{F_AND, F_OR, F_ADD, F_XOR, F_NOR, F_SUB, F_SLT, F_NOP};

    always #5 clka = ~clka;

    r_cpu_seq_ctrl #(.CNT_W(16), .OF_TRAP(1'b1)) u_dut0 (
        .clka(clka), .rsta(rsta), .runa(runa), .opa(opa), .funca(funca), .ofa(ofa),
        .pc_wea(pcw[0]), .ir_wea(irw[0]), .ab_wea(abw[0]), .reg_wea(rgw[0]),
        .aopa(aop[0]), .statea(st[0]), .illa(ill[0]), .ofta(oft[0]), .retcnt(ret0)
    );

    r_cpu_seq_ctrl #(.CNT_W(2), .OF_TRAP(1'b0)) u_dut1 (
        .clka(clka), .rsta(rsta), .runa(runa), .opa(opa), .funca(funca), .ofa(ofa),
        .pc_wea(pcw[1]), .ir_wea(irw[1]), .ab_wea(abw[1]), .reg_wea(rgw[1]),
        .aopa(aop[1]), .statea(st[1]), .illa(ill[1]), .ofta(oft[1]), .retcnt(ret1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ALU code for a function field, -1 when the function is not legal.
    function automatic int alu_code(input logic [5:0] f);
        case (f)
            F_AND: return 0;
            F_OR:  return 1;
            F_ADD: return 2;
            F_XOR: return 3;
            F_NOR: return 4;
            F_SUB: return 6;
            F_SLT: return 7;
            F_NOP: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_aop[k] = 0; m_func[k] = 0; m_trap[k] = 0;
            m_ill[k] = 0; m_oft[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // One clock of instruction progress, using the inputs seen before the edge.
    task automatic model_step(input int k);
        case (m_st[k])
            0: if (runa) m_st[k] = 1;
            1: m_st[k] = 2;
            2: begin
                if (opa == 6'd0 && alu_code(funca) >= 0) begin
                    m_aop[k]  = alu_code(funca);
                    m_func[k] = int'(funca);
                    m_st[k]   = 3;
                end else begin
                    m_ill[k] = 1;
                    m_st[k]  = 5;
                end
            end
            3: begin
                m_trap[k] = (p_oftrap[k] != 0 && ofa &&
                             (m_func[k] == int'(F_ADD) || m_func[k] == int'(F_SUB))) ? 1 : 0;
                m_st[k] = 4;
            end
            4: begin
                if (m_trap[k] != 0) begin
                    m_oft[k] = 1;
                    m_st[k]  = 5;
                end else begin
                    if (m_cnt[k] < p_cntmax[k]) m_cnt[k]++;
                    m_st[k] = runa ? 1 : 0;
                end
            end
            default: m_st[k] = 5;
        endcase
    endtask

    task automatic check_all();
        int r;
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? int'(ret0) : int'(ret1);
            chk($sformatf("i%0d_state", k), int'(st[k]), m_st[k]);
            chk($sformatf("i%0d_pc_we", k), int'(pcw[k]), (m_st[k] == 1) ? 1 : 0);
            chk($sformatf("i%0d_ir_we", k), int'(irw[k]), (m_st[k] == 1) ? 1 : 0);
            chk($sformatf("i%0d_ab_we", k), int'(abw[k]), (m_st[k] == 2) ? 1 : 0);
            chk($sformatf("i%0d_reg_we", k), int'(rgw[k]),
                (m_st[k] == 4 && m_func[k] != 0 && m_trap[k] == 0) ? 1 : 0);
            chk($sformatf("i%0d_aop", k), int'(aop[k]), m_aop[k]);
            chk($sformatf("i%0d_ill", k), int'(ill[k]), m_ill[k]);
            chk($sformatf("i%0d_oft", k), int'(oft[k]), m_oft[k]);
            chk($sformatf("i%0d_retcnt", k), r, m_cnt[k]);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clka);
        #1;
        if (pcw[0]) pc_pulses++;
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        rsta = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clka);
        #1;
        check_all();
        rsta = 1'b1;
    endtask

    initial begin
        rsta = 1'b0; runa = 1'b0; opa = 6'd0; funca = F_NOP; ofa = 1'b0;
        model_reset();
        #3;
        check_all();
        @(posedge clka); #1;
        rsta = 1'b1;

        // Single ADD: states 1,2,3,4,1 and one retirement.
        runa = 1'b1; funca = F_ADD;
        tick(); chk("add_st1", int'(st[0]), 1);
        tick(); chk("add_st2", int'(st[0]), 2);
        tick(); chk("add_aop", int'(aop[0]), 2);
        tick(); chk("add_reg_we", int'(rgw[0]), 1);
        tick(); chk("add_st_fetch", int'(st[0]), 1);
        chk("add_ret", int'(ret0), 1);
        async_reset();

        // Five back-to-back ops, run dropped during the last one.
        begin
            logic [5:0] f5 [5] = '{F_AND, F_OR, F_SUB, F_SLT, F_NOR};
            int         a5 [5] = '{0, 1, 6, 7, 4};
            pc_pulses = 0;
            runa = 1'b1;
            tick();
            for (int i = 0; i < 5; i++) begin
                funca = f5[i];
                tick();
                tick();
                chk($sformatf("seq_aop%0d", i), int'(aop[0]), a5[i]);
                if (i == 4) runa = 1'b0;
                tick();
                tick();
            end
            chk("seq_ret", int'(ret0), 5);
            chk("seq_pc_pulses", pc_pulses, 5);
            chk("seq_idle", int'(st[0]), 0);
        end
        async_reset();

        // Illegal opcode: HALT is absorbing.
        runa = 1'b1; opa = 6'b100011; funca = F_ADD;
        tick(); tick(); tick();
        chk("ill_halt", int'(st[0]), 5);
        chk("ill_flag", int'(ill[0]), 1);
        for (int i = 0; i < 6; i++) begin
            runa = i[0];
            tick();
        end
        chk("ill_still_halt", int'(st[0]), 5);
        chk("ill_ret", int'(ret0), 0);
        async_reset();
        chk("ill_cleared", int'(ill[0]), 0);

        // SUB with overflow: trap on instance 0, writeback on instance 1.
        opa = 6'd0; funca = F_SUB; ofa = 1'b1; runa = 1'b1;
        tick(); tick(); tick(); tick();
        chk("of_reg_we_trap", int'(rgw[0]), 0);
        chk("of_reg_we_notrap", int'(rgw[1]), 1);
        tick();
        chk("of_halt", int'(st[0]), 5);
        chk("of_flag", int'(oft[0]), 1);
        chk("of_continue", int'(st[1]), 1);
        ofa = 1'b0;
        async_reset();

        // Run dropped in DECODE: instruction completes, then park and resume.
        funca = F_OR; runa = 1'b1;
        tick(); tick();
        runa = 1'b0;
        tick(); tick();
        chk("drop_reg_we", int'(rgw[0]), 1);
        tick(); chk("drop_idle", int'(st[0]), 0);
        tick(); chk("drop_idle2", int'(st[0]), 0);
        runa = 1'b1;
        tick(); chk("drop_resume", int'(st[0]), 1);
        tick(); tick();
        chk("mid_exec", int'(st[0]), 3);
        #2;
        rsta = 1'b0;
        #1;
        model_reset();
        chk("rst_async_state", int'(st[0]), 0);
        chk("rst_async_ab", int'(abw[0]), 0);
        check_all();
        @(posedge clka); #1;
        check_all();
        rsta = 1'b1;

        // Five NOPs: the 2-bit counter saturates at 3.
        funca = F_NOP; runa = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("nop_sat", int'(ret1), 3);
        chk("nop_ret16", int'(ret0), 5);
        async_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            runa  = ($urandom_range(0, 7) != 0);
            ofa   = ($urandom_range(0, 5) == 0);
            opa   = ($urandom_range(0, 24) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            funca = ($urandom_range(0, 24) == 0) ? 6'($urandom_range(0, 63))
                                                 : legal_f[$urandom_range(0, 7)];
            if ((m_st[0] == 5 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                async_reset();
            else
                tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/r_cpu_seq_ctrl.md
Name: r_cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the R-type CPU datapath: instruction memory, program counter, register file and ALU.
- Replaces the single-cycle control by splitting each instruction into FETCH, DECODE, EXEC and WB, and drives every datapath write enable and the ALU opcode.
- Traps illegal instructions and, optionally, arithmetic overflow.
- Counts retired instructions for debug/bring-up.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- OF_TRAP, 1, when 1 an overflowing add/sub suppresses writeback and halts the sequencer.

Ports:
- clka  input  1  system clock; all state updates on the rising edge.
- rsta  input  1  asynchronous active-low reset.
- runa  input  1  level run enable; sampled in IDLE and WB.
- opa  input  6  instruction opcode field Inst[31:26], valid from the cycle after FETCH.
- funca  input  6  instruction function field Inst[5:0].
- ofa  input  1  ALU overflow flag, valid during EXEC.
- pc_wea  output  1  PC increments by 4 at the end of the cycle.
- ir_wea  output  1  instruction register load.
- ab_wea  output  1  register-file operand latches A/B load.
- reg_wea  output  1  register-file write (rd <= ALU result).
- aopa  output  3  ALU operation.
- statea  output  3  current state encoding.
- illa  output  1  sticky illegal-instruction flag.
- ofta  output  1  sticky overflow-trap flag.
- retcnt  output  CNT_W  retired-instruction count.

Behaviour:
- States (statea encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6–7 go to IDLE on the next edge.
- Reset (rsta=0, asynchronous): state=IDLE, aopa=3'b000, illa=0, ofta=0, retcnt=0.
  - All strobes are 0 during reset and in IDLE/HALT.
  - Reset asserted mid-instruction aborts it immediately; no strobe fires afterwards.
- Strobes are Moore outputs decoded from the state register:
  - pc_wea=ir_wea=1 only in FETCH.
  - ab_wea=1 only in DECODE.
  - reg_wea=1 only in WB, subject to the gating below.
- IDLE: runa=1 -> FETCH, else stay.
- FETCH -> DECODE unconditionally.
- DECODE: classify the {opa,funca} held in the instruction register.
  - Legal instructions require opa=6'b000000.
  - funca mapping to ALU op register: 100100 AND->000, 100101 OR->001, 100000 ADD->010, 100110 XOR->011, 100111 NOR->100, 100010 SUB->110, 101010 SLT->111.
  - funca=000000 is a NOP: legal, aopa=000, writeback suppressed.
  - Legal -> EXEC; aopa is updated at the end of DECODE and then held.
  - Any other combination -> HALT, illa=1, aopa unchanged.
- EXEC: ALU settles; ofa is sampled at the end of EXEC into an internal trap bit.
  - The trap bit is set only when OF_TRAP=1 and the op is ADD or SUB.
  - EXEC -> WB.
- WB: reg_wea=1 unless NOP or the trap bit is set.
  - Trap set: reg_wea=0, ofta=1, next state HALT, retcnt unchanged.
  - Otherwise retcnt increments, saturating at all-ones; next state FETCH if runa=1, else IDLE.
  - NOP counts as retired.
- HALT: absorbing; only rsta exits. illa and ofta hold.
- Throughput: exactly 4 cycles per instruction while runa=1. PC advances once per instruction, in FETCH.
- runa deasserted in FETCH, DECODE or EXEC: the instruction completes through WB, then the sequencer parks in IDLE.

Test Plan:
- Reset, then runa=1 with ADD (op=0, func=100000): states 1,2,3,4,1; pc_wea in cycle 1 only; aopa=010 from cycle 3; reg_wea=1 in cycle 4; retcnt=1.
- Five back-to-back legal ops (AND, OR, SUB, SLT, NOR): aopa sequence 000, 001, 110, 111, 100; retcnt=5 after 20 cycles; exactly 5 pc_wea pulses.
- op=6'b100011 (illegal): DECODE -> HALT, illa=1; no ab_wea after HALT entry, no reg_wea; retcnt unchanged; runa toggling has no effect; rsta low clears to IDLE.
- OF_TRAP=1, SUB with ofa=1 in EXEC: reg_wea=0 in WB, ofta=1, HALT. Same stimulus with OF_TRAP=0: reg_wea=1 and the sequencer continues.
- runa dropped in DECODE: EXEC and WB still complete with reg_wea=1, then IDLE; raising runa resumes at FETCH.
- rsta asserted mid-EXEC: state=0 and all strobes 0 asynchronously, before the next clock edge; CNT_W=2 with 5 NOPs: retcnt saturates at 3.
